// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled start/data/stop deserializer feeding a first-word-fall-through byte FIFO.
// Define RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and the sticky PARERR flag.
module uart_receiver #(
  parameter int DEPTH = 16,
  parameter int OSR   = 16
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic                       EN,
  input  logic [7:0]                 BAUD,
  input  logic                       RX,
  input  logic                       RD,
  input  logic                       CLR,
`ifdef RX_PARITY_EN
  input  logic                       PARITY_ODD,
  output logic                       PARERR,
`endif
  output logic [7:0]                 DATAOUT,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       RXEMPTY,
  output logic                       RXFULL,
  output logic                       OVERRUN,
  output logic                       FRAMEERR,
  output logic [2:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [3:0] SMP_MID  = 4'(OSR/2 - 1);
  localparam logic [3:0] SMP_LAST = 4'(OSR - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic            prev_q, prev_d;
  logic [7:0]      tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [3:0]      smp_q, smp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_req, frame_set;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d, fe_q, fe_d;
  logic            full, do_pop, do_push, ovr_set;
`ifdef RX_PARITY_EN
  logic            par_bad_q, par_bad_d, pe_q, pe_d, par_set;
`endif

  assign rx_s = sync_q[1];

  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = 8'd0;
    if (EN) begin
      if (tick_cnt_q == BAUD) tick = 1'b1;
      else                    tick_cnt_d = tick_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    prev_d    = prev_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    if (!EN) begin
      state_d = S_IDLE;
      smp_d   = 4'd0;
      bit_d   = 3'd0;
    end else if (tick) begin
      prev_d = rx_s;
      smp_d  = smp_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          smp_d = 4'd0;
          bit_d = 3'd0;
`ifdef RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
          // Only a falling edge starts a frame, so a stuck-low line cannot retrigger.
          if (!rx_s && prev_q) state_d = S_START;
        end
        S_START: if (smp_q == SMP_MID) begin
          smp_d   = 4'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (smp_q == SMP_LAST) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
`ifdef RX_PARITY_EN
        S_PARITY: if (smp_q == SMP_LAST) begin
          if (rx_s != (^shift_q ^ PARITY_ODD)) begin
            par_set   = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = S_STOP;
        end
`endif
        S_STOP: if (smp_q == SMP_LAST) begin
`ifdef RX_PARITY_EN
          if (rx_s) push_req = !par_bad_q;
`else
          if (rx_s) push_req = 1'b1;
`endif
          else      frame_set = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // RD pops the head when non-empty; a same-cycle pop frees the slot for a push into a full FIFO.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_pop   = RD && (count_q != '0);
    do_push  = push_req && (!full || do_pop);
    ovr_set  = push_req && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ovr_d    = ovr_set   | (ovr_q & ~CLR);
    fe_d     = frame_set | (fe_q  & ~CLR);
`ifdef RX_PARITY_EN
    pe_d     = par_set   | (pe_q  & ~CLR);
`endif
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      tick_cnt_q <= 8'd0;
      state_q    <= S_IDLE;
      smp_q      <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q  <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], RX};
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
`ifdef RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      pe_q       <= pe_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign DATAOUT   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign COUNT     = count_q;
  assign RXEMPTY   = (count_q == '0);
  assign RXFULL    = full;
  assign OVERRUN   = ovr_q;
  assign FRAMEERR  = fe_q;
  assign state_dbg = state_q;
`ifdef RX_PARITY_EN
  assign PARERR    = pe_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven bit by bit, FIFO and sticky flags predicted by a queue model.
module tb_uart_receiver;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // At BAUD=0 from an idle line: 2 sync cycles, edge tick, 8 start ticks, then 16 ticks per remaining bit.
  localparam int PUSH_C = 2 + 8 + 16*(NBITS-1);

  logic          CLK, NRST, EN, RX, RD, CLR;
  logic [7:0]    BAUD;
  logic [7:0]    DATAOUT;
  logic [CW-1:0] COUNT;
  logic          RXEMPTY, RXFULL, OVERRUN, FRAMEERR;
  logic [2:0]    state_dbg;
`ifdef RX_PARITY_EN
  logic          PARITY_ODD, PARERR;
`endif

  uart_receiver #(.DEPTH(DEPTH), .OSR(16)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .BAUD(BAUD), .RX(RX), .RD(RD), .CLR(CLR),
`ifdef RX_PARITY_EN
    .PARITY_ODD(PARITY_ODD), .PARERR(PARERR),
`endif
    .DATAOUT(DATAOUT), .COUNT(COUNT), .RXEMPTY(RXEMPTY), .RXFULL(RXFULL),
    .OVERRUN(OVERRUN), .FRAMEERR(FRAMEERR), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: FIFO contents and sticky flags
  logic [7:0] exp_q[$];
  bit exp_ovr, exp_fe, exp_pe;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check_val({tag, ".count"},    32'(COUNT),    32'(exp_q.size()));
    check_val({tag, ".dataout"},  32'(DATAOUT),  32'(head));
    check_val({tag, ".rxempty"},  32'(RXEMPTY),  32'(exp_q.size() == 0));
    check_val({tag, ".rxfull"},   32'(RXFULL),   32'(exp_q.size() == DEPTH));
    check_val({tag, ".overrun"},  32'(OVERRUN),  32'(exp_ovr));
    check_val({tag, ".frameerr"}, 32'(FRAMEERR), 32'(exp_fe));
`ifdef RX_PARITY_EN
    check_val({tag, ".parerr"},   32'(PARERR),   32'(exp_pe));
`endif
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    bit par_bad;
    par_bad = 1'b0;
`ifdef RX_PARITY_EN
    par_bad = par_flip;
    if (par_bad) exp_pe = 1'b1;
`endif
    if (!stop_bit)                exp_fe = 1'b1;
    else if (par_bad)             ;
    else if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
    else                          exp_q.push_back(b);
  endfunction

  // Driver tasks: everything changes on the falling clock edge
  task automatic frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                       input bit exact, input bit rd_on_push);
    int bitlen;
    logic bits [NBITS];
    bitlen = 16 * (int'(BAUD) + 1);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef RX_PARITY_EN
    bits[9] = ^b ^ PARITY_ODD ^ par_flip;
`endif
    bits[NBITS-1] = stop_bit;
    for (int c = 0; c < NBITS * bitlen; c++) begin
      if (exact && c == PUSH_C) check_state("pre_push");
      if (exact && c == PUSH_C + 1) begin
        if (rd_on_push && exp_q.size() > 0) void'(exp_q.pop_front());
        model_frame(b, stop_bit, par_flip);
        check_state("post_push");
      end
      RX = bits[c / bitlen];
      RD = exact && rd_on_push && (c == PUSH_C);
      @(negedge CLK);
    end
    RD = 1'b0;
    RX = 1'b1;
    repeat (bitlen) @(negedge CLK);
    if (!exact) model_frame(b, stop_bit, par_flip);
  endtask

  task automatic pop();
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    exp_pe  = 1'b0;
  endtask

  task automatic set_baud(input logic [7:0] v);
    EN   = 1'b0;
    BAUD = v;
    @(negedge CLK);
    EN = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] b;
    NRST = 1'b0; EN = 1'b0; RX = 1'b1; RD = 1'b0; CLR = 1'b0; BAUD = 8'd3;
`ifdef RX_PARITY_EN
    PARITY_ODD = 1'b0;
`endif
    exp_ovr = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    repeat (3) @(negedge CLK);
    check_state("reset");
    check_val("reset.state", 32'(state_dbg), 32'd0);
    NRST = 1'b1;
    @(negedge CLK);
    set_baud(8'd3);

    frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("a5");
    pop();
    check_state("a5_pop");

    RX = 1'b0;
    repeat (20) @(negedge CLK);
    RX = 1'b1;
    repeat (128) @(negedge CLK);
    check_val("glitch.state", 32'(state_dbg), 32'd0);
    check_state("glitch");

    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("frame_err");
    pulse_clr();
    check_state("frame_err_clr");

    // Randomized frames, baud rates, pops and clears
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 3) == 0) set_baud(8'($urandom_range(0, 3)));
      b = 8'($urandom);
      frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, 1'b0, 1'b0);
      check_state("rand_frame");
      if ($urandom_range(0, 1) == 1) begin
        pop();
        check_state("rand_pop");
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        check_state("rand_clr");
      end
    end
    while (exp_q.size() > 0) pop();
    pop();
    pulse_clr();
    check_state("flushed");

    set_baud(8'd3);
    for (int i = 0; i <= DEPTH; i++) frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("overflow");
    for (int i = 0; i < DEPTH; i++) begin
      check_state("drain");
      pop();
    end
    check_state("drained");
    pulse_clr();
    check_state("ovr_clr");

    set_baud(8'd0);
    frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++) frame(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("refill");
    frame(8'hEE, 1'b1, 1'b0, 1'b1, 1'b1);
    check_state("full_push_pop");
    while (exp_q.size() > 0) begin
      check_state("drain2");
      pop();
    end

    set_baud(8'd3);
    for (int c = 0; c < 4 * 64; c++) begin
      RX = (c < 64) ? 1'b0 : ((c / 64) % 2 == 1);
      @(negedge CLK);
    end
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("midreset.state", 32'(state_dbg), 32'd0);
    RX = 1'b1;
    NRST = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    @(negedge CLK);
    check_state("midreset");
    frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("after_reset");

`ifdef RX_PARITY_EN
    PARITY_ODD = 1'b0;
    frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("par_ok");
    frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("par_bad");
    pulse_clr();
    check_state("par_clr");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive path of the serial peripheral. Converts the RX line into bytes and buffers them for the CPU's data register read.
- Sits beside the transmit path and shares the baud divisor value with it.
- Provides a 16x-oversampled start/data/stop deserializer, a receive FIFO, and sticky error flags that feed the status register and interrupt logic.

Parameters:
DEPTH, 16, receive FIFO depth in bytes (power of two, minimum 2)
OSR, 16, oversampling ticks per bit (fixed at 16; mid-bit sample at tick 7)

Ports:
CLK  input  1  system clock
NRST  input  1  reset, asynchronous, active-low
EN  input  1  receiver enable (status bits [1]&[0] at top level)
BAUD  input  8  baud divisor; one sample tick every BAUD+1 CLK cycles
RX  input  1  serial receive line, idle high, asynchronous to CLK
RD  input  1  pop strobe, one CLK wide (CPU read of the data register while selected)
CLR  input  1  clears OVERRUN and FRAMEERR
DATAOUT  output  8  FIFO head byte (first-word fall-through); 8'h00 when empty
COUNT  output  $clog2(DEPTH+1)  bytes held
RXEMPTY  output  1  COUNT==0
RXFULL  output  1  COUNT==DEPTH
OVERRUN  output  1  sticky: byte arrived while FIFO full
FRAMEERR  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (NRST low, asynchronous): FSM=IDLE; tick and bit counters=0; FIFO empty; DATAOUT=0; COUNT=0; RXEMPTY=1; RXFULL=0; OVERRUN=0; FRAMEERR=0; synchronizer and previous-sample registers=1.
- Reset mid-frame aborts the frame. No partial byte is pushed.
- RX passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick generator: an 8-bit counter runs while EN=1. It pulses a tick and wraps to 0 when count==BAUD. BAUD=0 gives a tick every cycle.
- EN low clears the tick counter and forces IDLE. FIFO contents and flags are kept.
- FSM advances only on ticks. A 4-bit sample counter and a 3-bit bit index are used.
  - IDLE: start is detected when the sampled RX is 0 and the previous tick's sample was 1 (falling edge). Then sample counter=0 and go to START. A line held low never retriggers.
  - START: at sample count 7, RX=1 means false start and the FSM returns to IDLE. RX=0 clears the sample counter and goes to DATA.
  - DATA: every 16th tick (count 15→0) sample RX into a shift register, LSB first. After bit index 7, go to STOP (or PARITY when enabled).
  - STOP: sample at the 16th tick.
    - RX=1: push the byte.
    - RX=0: set FRAMEERR and discard the byte.
    - Either way return to IDLE.
- Latency: the byte is visible on DATAOUT and COUNT in the cycle after the stop-bit sample tick.
- FIFO: circular buffer with read/write pointers and COUNT. RD while empty is ignored.
  - Push while full (no RD that cycle): drop the byte and set OVERRUN.
  - Push and RD in the same cycle: both happen; COUNT is unchanged; no overrun even when full.
  - Pointers wrap modulo DEPTH.
- CLR clears both sticky flags. If an error event lands in the same cycle as CLR, set wins.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - Adds input PARITY_ODD (1 bit) and a sticky output PARERR.
  - Adds a PARITY state between DATA and STOP. It samples one bit at the 16th tick.
  - Expected parity: even parity is XOR of the data bits; odd parity is its inverse.
  - On mismatch: set PARERR and discard the byte. STOP still runs and its checks still apply.
  - CLR clears PARERR.
- Undefined: no PARITY state, port, or flag. The frame is 8N1.

Test Plan:
- BAUD=3 (64 CLK per bit), EN=1, send 8N1 byte 8'hA5 → ~10 bit-times later DATAOUT=8'hA5, COUNT=1, RXEMPTY=0; RD → COUNT=0, DATAOUT=8'h00.
- RX low pulse of 20 CLK (under half a bit at BAUD=3) → no byte, FSM back in IDLE, COUNT stays 0.
- Frame 8'h3C with stop bit driven low → FRAMEERR=1, COUNT=0; CLR → FRAMEERR=0.
- DEPTH=16: send 17 bytes 8'h00..8'h10 without RD → RXFULL=1, OVERRUN=1, 16 pops return 8'h00..8'h0F in order; then RXFULL=1 with RD asserted on the 17th stop tick → no OVERRUN, COUNT stays 16.
- Assert NRST low mid-DATA of 8'h55, release, send 8'h81 → only 8'h81 received, COUNT=1.
- With RX_PARITY_EN, PARITY_ODD=0: 8'h07 with parity bit 1 → accepted; 8'h07 with parity bit 0 → PARERR=1, COUNT unchanged.
